// File: rtl/alu_issue_stage.sv
// Two-entry skid buffer between decode and the ALU. Instructions are decoded
// when they are accepted, and the outputs always show the registered head entry.
module alu_issue_stage #(
   parameter int DATA_WIDTH    = 32,
   parameter int OPCODE_LENGTH = 4,
   parameter int PC_WIDTH      = 9
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [31:0]              in_instr,
   input  logic [PC_WIDTH-1:0]      in_pc,
   input  logic [DATA_WIDTH-1:0]    in_rs1_data,
   input  logic [DATA_WIDTH-1:0]    in_rs2_data,
   input  logic                     flush,
   input  logic                     ex_ready,
   output logic                     out_valid,
   output logic [OPCODE_LENGTH-1:0] out_operation,
   output logic [DATA_WIDTH-1:0]    out_srca,
   output logic [DATA_WIDTH-1:0]    out_srcb,
   output logic [PC_WIDTH-1:0]      out_pc,
   output logic [4:0]               out_rd,
   output logic                     out_is_branch,
   output logic                     out_illegal
);

   typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_t;

   typedef struct packed {
      logic [OPCODE_LENGTH-1:0] op;
      logic [DATA_WIDTH-1:0]    srca;
      logic [DATA_WIDTH-1:0]    srcb;
      logic [PC_WIDTH-1:0]      pc;
      logic [4:0]               rd;
      logic                     isBranch;
      logic                     illegal;
   } entry_t;

   localparam logic [OPCODE_LENGTH-1:0] OP_AND = OPCODE_LENGTH'(4'b0000);
   localparam logic [OPCODE_LENGTH-1:0] OP_OR  = OPCODE_LENGTH'(4'b0001);
   localparam logic [OPCODE_LENGTH-1:0] OP_ADD = OPCODE_LENGTH'(4'b0010);
   localparam logic [OPCODE_LENGTH-1:0] OP_SUB = OPCODE_LENGTH'(4'b0011);
   localparam logic [OPCODE_LENGTH-1:0] OP_XOR = OPCODE_LENGTH'(4'b0100);
   localparam logic [OPCODE_LENGTH-1:0] OP_SLL = OPCODE_LENGTH'(4'b0101);
   localparam logic [OPCODE_LENGTH-1:0] OP_SRL = OPCODE_LENGTH'(4'b0110);
   localparam logic [OPCODE_LENGTH-1:0] OP_SRA = OPCODE_LENGTH'(4'b0111);
   localparam logic [OPCODE_LENGTH-1:0] OP_BEQ = OPCODE_LENGTH'(4'b1000);
   localparam logic [OPCODE_LENGTH-1:0] OP_SLT = OPCODE_LENGTH'(4'b1001);
   localparam logic [OPCODE_LENGTH-1:0] OP_BGE = OPCODE_LENGTH'(4'b1010);
   localparam logic [OPCODE_LENGTH-1:0] OP_BLT = OPCODE_LENGTH'(4'b1011);
   localparam logic [OPCODE_LENGTH-1:0] OP_BNE = OPCODE_LENGTH'(4'b1100);
   localparam logic [OPCODE_LENGTH-1:0] OP_JMP = OPCODE_LENGTH'(4'b1101);
   localparam logic [OPCODE_LENGTH-1:0] OP_ILL = OPCODE_LENGTH'(4'b1111);

   localparam entry_t RESET_ENTRY = '{op: OP_ILL, default: '0};

   occ_t   stateQ, stateD;
   entry_t headQ, headD;
   entry_t tailQ, tailD;
   entry_t decEntry;

   logic                  accept;
   logic                  pop;
   logic [2:0]            funct3;
   logic [DATA_WIDTH-1:0] immI, immS, immU, shamt;

   assign funct3 = in_instr[14:12];
   assign immI   = {{(DATA_WIDTH-12){in_instr[31]}}, in_instr[31:20]};
   assign immS   = {{(DATA_WIDTH-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
   assign immU   = DATA_WIDTH'({in_instr[31:12], 12'b0});
   assign shamt  = {{(DATA_WIDTH-5){1'b0}}, in_instr[24:20]};

   // Decode the offered instruction; anything unsupported collapses to an
   // illegal entry with zero operands so the ALU never sees stale data.
   always_comb begin
      decEntry          = '0;
      decEntry.op       = OP_ILL;
      decEntry.pc       = in_pc;
      decEntry.rd       = in_instr[11:7];
      decEntry.srca     = in_rs1_data;
      unique case (in_instr[6:0])
         7'b0110011, 7'b0010011: begin
            if (in_instr[5]) begin
               decEntry.srcb = in_rs2_data;
            end else if (funct3 == 3'b001 || funct3 == 3'b101) begin
               decEntry.srcb = shamt;
            end else begin
               decEntry.srcb = immI;
            end
            case (funct3)
               3'b000:  decEntry.op = (in_instr[5] && in_instr[30]) ? OP_SUB : OP_ADD;
               3'b001:  decEntry.op = OP_SLL;
               3'b010:  decEntry.op = OP_SLT;
               3'b100:  decEntry.op = OP_XOR;
               3'b101:  decEntry.op = in_instr[30] ? OP_SRA : OP_SRL;
               3'b110:  decEntry.op = OP_OR;
               3'b111:  decEntry.op = OP_AND;
               default: decEntry.illegal = 1'b1;
            endcase
         end
         7'b0000011: begin
            decEntry.op   = OP_ADD;
            decEntry.srcb = immI;
         end
         7'b0100011: begin
            decEntry.op   = OP_ADD;
            decEntry.srcb = immS;
         end
         7'b1100011: begin
            decEntry.srcb     = in_rs2_data;
            decEntry.isBranch = 1'b1;
            case (funct3)
               3'b000:  decEntry.op = OP_BEQ;
               3'b001:  decEntry.op = OP_BNE;
               3'b100:  decEntry.op = OP_BLT;
               3'b101:  decEntry.op = OP_BGE;
               default: decEntry.illegal = 1'b1;
            endcase
         end
         7'b1101111, 7'b1100111: begin
            decEntry.op = OP_JMP;
         end
         7'b0110111: begin
            decEntry.op   = OP_ADD;
            decEntry.srca = '0;
            decEntry.srcb = immU;
         end
         default: decEntry.illegal = 1'b1;
      endcase
      if (decEntry.illegal) begin
         decEntry.op       = OP_ILL;
         decEntry.srca     = '0;
         decEntry.srcb     = '0;
         decEntry.isBranch = 1'b0;
      end
   end

   assign in_ready  = (stateQ != TWO);
   assign out_valid = (stateQ != EMPTY);
   assign accept    = in_valid && in_ready;
   assign pop       = out_valid && ex_ready;

   // Occupancy FSM: the head always holds the oldest entry, the tail only
   // fills when the ALU stalls with one entry already waiting.
   always_comb begin
      stateD = stateQ;
      headD  = headQ;
      tailD  = tailQ;
      if (flush) begin
         stateD = EMPTY;
      end else begin
         case (stateQ)
            EMPTY: if (accept) begin
               headD  = decEntry;
               stateD = ONE;
            end
            ONE: begin
               if (accept && pop) begin
                  headD = decEntry;
               end else if (accept) begin
                  tailD  = decEntry;
                  stateD = TWO;
               end else if (pop) begin
                  stateD = EMPTY;
               end
            end
            TWO: if (pop) begin
               headD  = tailQ;
               stateD = ONE;
            end
            default: stateD = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stateQ <= EMPTY;
         headQ  <= RESET_ENTRY;
         tailQ  <= RESET_ENTRY;
      end else begin
         stateQ <= stateD;
         headQ  <= headD;
         tailQ  <= tailD;
      end
   end

   assign out_operation = headQ.op;
   assign out_srca      = headQ.srca;
   assign out_srcb      = headQ.srcb;
   assign out_pc        = headQ.pc;
   assign out_rd        = headQ.rd;
   assign out_is_branch = headQ.isBranch;
   assign out_illegal   = headQ.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: expected head entries are queued as
// instructions are accepted and compared when the ALU side consumes them.
module tb_alu_issue_stage;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_instr = '0;
   logic [8:0]  in_pc = '0;
   logic [31:0] in_rs1_data = '0;
   logic [31:0] in_rs2_data = '0;
   logic        flush = 1'b0;
   logic        ex_ready = 1'b0;
   logic        out_valid;
   logic [3:0]  out_operation;
   logic [31:0] out_srca;
   logic [31:0] out_srcb;
   logic [8:0]  out_pc;
   logic [4:0]  out_rd;
   logic        out_is_branch;
   logic        out_illegal;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [8:0]  pc;
      logic [4:0]  rd;
      logic        br;
      logic        ill;
   } exp_t;

   exp_t sbQ[$];
   int   checkCount = 0;
   int   errorCount = 0;

   alu_issue_stage #(.DATA_WIDTH(32), .OPCODE_LENGTH(4), .PC_WIDTH(9)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .in_rs1_data(in_rs1_data),
      .in_rs2_data(in_rs2_data), .flush(flush), .ex_ready(ex_ready),
      .out_valid(out_valid), .out_operation(out_operation), .out_srca(out_srca),
      .out_srcb(out_srcb), .out_pc(out_pc), .out_rd(out_rd),
      .out_is_branch(out_is_branch), .out_illegal(out_illegal)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
      end
   endtask

   // Offer one instruction until the DUT takes it; the entry is queued when
   // in_ready (state-driven, so stable all cycle) shows it will be accepted.
   task automatic applyStimulus(input logic [31:0] instr, input logic [8:0] pc,
                                input logic [31:0] rs1, input logic [31:0] rs2,
                                input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic br, input logic ill);
      exp_t e;
      bit   done = 0;
      in_valid    = 1'b1;
      in_instr    = instr;
      in_pc       = pc;
      in_rs1_data = rs1;
      in_rs2_data = rs2;
      for (int i = 0; i < 50 && !done; i++) begin
         if (in_ready) begin
            e.op = op; e.a = a; e.b = b; e.pc = pc; e.rd = instr[11:7]; e.br = br; e.ill = ill;
            sbQ.push_back(e);
            done = 1;
         end
         @(posedge clk);
         #1;
      end
      if (!done) checkOutput("acceptTimeout", 64'd0, 64'd1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      ex_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      checkOutput("drainEmpty", 64'(sbQ.size()), 64'd0);
      checkOutput("drainValid", 64'(out_valid), 64'd0);
   endtask

   // Consumer side: whatever is at the head when the ALU is ready is compared
   // against the oldest scoreboard entry.
   always @(negedge clk) begin
      exp_t e;
      if (!reset && out_valid && ex_ready) begin
         if (sbQ.size() == 0) begin
            checkOutput("spuriousOut", 64'(out_valid), 64'd0);
         end else begin
            e = sbQ.pop_front();
            checkOutput("op", 64'(out_operation), 64'(e.op));
            checkOutput("srca", 64'(out_srca), 64'(e.a));
            checkOutput("srcb", 64'(out_srcb), 64'(e.b));
            checkOutput("pc", 64'(out_pc), 64'(e.pc));
            checkOutput("rd", 64'(out_rd), 64'(e.rd));
            checkOutput("isBranch", 64'(out_is_branch), 64'(e.br));
            checkOutput("illegal", 64'(out_illegal), 64'(e.ill));
         end
      end
   end

   initial begin
      #2 reset = 1'b1;
      #1;
      checkOutput("rstValid", 64'(out_valid), 64'd0);
      checkOutput("rstReady", 64'(in_ready), 64'd1);
      checkOutput("rstOp", 64'(out_operation), 64'hF);
      checkOutput("rstSrca", 64'(out_srca), 64'd0);
      checkOutput("rstSrcb", 64'(out_srcb), 64'd0);
      checkOutput("rstPc", 64'(out_pc), 64'd0);
      checkOutput("rstRd", 64'(out_rd), 64'd0);
      checkOutput("rstBranch", 64'(out_is_branch), 64'd0);
      checkOutput("rstIllegal", 64'(out_illegal), 64'd0);
      #9 reset = 1'b0;
      @(posedge clk);
      #1;

      // Streaming decode with the ALU always ready
      ex_ready = 1'b1;
      applyStimulus(32'h002081B3, 9'h010, 32'd5, 32'd7, 4'b0010, 32'd5, 32'd7, 1'b0, 1'b0);
      checkOutput("addValid", 64'(out_valid), 64'd1);
      applyStimulus(32'h4040D093, 9'h014, 32'h80000000, 32'd0, 4'b0111, 32'h80000000, 32'd4, 1'b0, 1'b0);
      applyStimulus(32'h407302B3, 9'h018, 32'd20, 32'd6, 4'b0011, 32'd20, 32'd6, 1'b0, 1'b0);
      applyStimulus(32'hFFF00113, 9'h01C, 32'd9, 32'd3, 4'b0010, 32'd9, 32'hFFFFFFFF, 1'b0, 1'b0);
      applyStimulus(32'h00802203, 9'h020, 32'h100, 32'd0, 4'b0010, 32'h100, 32'd8, 1'b0, 1'b0);
      applyStimulus(32'hFE20AE23, 9'h024, 32'h200, 32'h55, 4'b0010, 32'h200, 32'hFFFFFFFC, 1'b0, 1'b0);
      applyStimulus(32'h123453B7, 9'h028, 32'hDEAD, 32'hBEEF, 4'b0010, 32'd0, 32'h12345000, 1'b0, 1'b0);
      applyStimulus(32'h00208063, 9'h02C, 32'd11, 32'd12, 4'b1000, 32'd11, 32'd12, 1'b1, 1'b0);
      applyStimulus(32'h0020E063, 9'h030, 32'd11, 32'd12, 4'b1111, 32'd0, 32'd0, 1'b0, 1'b1);
      applyStimulus(32'h000000EF, 9'h034, 32'd44, 32'd45, 4'b1101, 32'd44, 32'd0, 1'b0, 1'b0);
      applyStimulus(32'h0020B1B3, 9'h038, 32'd1, 32'd2, 4'b1111, 32'd0, 32'd0, 1'b0, 1'b1);
      applyStimulus(32'h0020C1B3, 9'h03C, 32'hF0F0, 32'h0FF0, 4'b0100, 32'hF0F0, 32'h0FF0, 1'b0, 1'b0);
      drain();

      // Back-pressure: two entries fill the buffer, the third waits at the sender
      ex_ready = 1'b0;
      applyStimulus(32'h002081B3, 9'h040, 32'd1, 32'd2, 4'b0010, 32'd1, 32'd2, 1'b0, 1'b0);
      applyStimulus(32'h407302B3, 9'h044, 32'd3, 32'd4, 4'b0011, 32'd3, 32'd4, 1'b0, 1'b0);
      checkOutput("fullReady", 64'(in_ready), 64'd0);
      in_valid = 1'b1;
      in_instr = 32'h0020C1B3;
      repeat (3) begin
         @(posedge clk);
         #1;
         checkOutput("stallReady", 64'(in_ready), 64'd0);
         checkOutput("stallHeadPc", 64'(out_pc), 64'h040);
      end
      ex_ready = 1'b1;
      applyStimulus(32'h0020C1B3, 9'h048, 32'd5, 32'd6, 4'b0100, 32'd5, 32'd6, 1'b0, 1'b0);
      drain();

      // Flush while full, with an instruction offered in the same cycle
      ex_ready = 1'b0;
      applyStimulus(32'h002081B3, 9'h050, 32'd1, 32'd2, 4'b0010, 32'd1, 32'd2, 1'b0, 1'b0);
      applyStimulus(32'h407302B3, 9'h054, 32'd3, 32'd4, 4'b0011, 32'd3, 32'd4, 1'b0, 1'b0);
      in_valid = 1'b1;
      in_instr = 32'h0020C1B3;
      flush    = 1'b1;
      @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      sbQ.delete();
      checkOutput("flushValid", 64'(out_valid), 64'd0);
      checkOutput("flushReady", 64'(in_ready), 64'd1);
      ex_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("flushLost", 64'(out_valid), 64'd0);

      // Asynchronous reset pulse between edges while one entry is held
      ex_ready = 1'b0;
      applyStimulus(32'h00208063, 9'h060, 32'd7, 32'd8, 4'b1000, 32'd7, 32'd8, 1'b1, 1'b0);
      #3;
      checkOutput("preRstValid", 64'(out_valid), 64'd1);
      reset = 1'b1;
      #1;
      checkOutput("midRstValid", 64'(out_valid), 64'd0);
      checkOutput("midRstOp", 64'(out_operation), 64'hF);
      checkOutput("midRstReady", 64'(in_ready), 64'd1);
      checkOutput("midRstBranch", 64'(out_is_branch), 64'd0);
      #1 reset = 1'b0;
      sbQ.delete();
      applyStimulus(32'h4040D093, 9'h064, 32'h80000000, 32'd0, 4'b0111, 32'h80000000, 32'd4, 1'b0, 1'b0);
      checkOutput("postRstValid", 64'(out_valid), 64'd1);
      checkOutput("postRstPc", 64'(out_pc), 64'h064);
      drain();

      $display("[TB] Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
